// File: rtl/multicycle_driver.sv
// Issue stage for a start/done multi-cycle unit: operand FIFO, one-at-a-time issue, result hold.
// Optional watchdog enabled by defining MC_TIMEOUT_EN.
module multicycle_driver #(
   parameter int WIDTH          = 32,
   parameter int FIFO_DEPTH     = 2,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             mc_start,
   output logic [WIDTH-1:0] mc_inp,
   input  logic             mc_done,
   input  logic [WIDTH-1:0] mc_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             busy,
   output logic             timeout_err
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two and at least 2");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   typedef enum logic {ST_IDLE, ST_WAIT} state_t;

   state_t            state_q, state_d;
   logic [AW:0]       wr_ptr_q, wr_ptr_d;
   logic [AW:0]       rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0]  fifo_q [FIFO_DEPTH];
   logic              mc_start_q, mc_start_d;
   logic [WIDTH-1:0]  mc_inp_q, mc_inp_d;
   logic              out_valid_q, out_valid_d;
   logic [WIDTH-1:0]  out_data_q, out_data_d;
   logic              full, empty, push, pop;
   logic [WIDTH-1:0]  head;

`ifdef MC_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              timeout_q, timeout_d;
`endif

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign in_ready = !full;
   assign push  = in_valid && !full;
   assign head  = fifo_q[rd_ptr_q[AW-1:0]];

   assign wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
   assign rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

   // Storage carries no reset; only the pointers define occupancy.
   always_ff @(posedge clock) begin
      if (push) begin
         fifo_q[wr_ptr_q[AW-1:0]] <= in_data;
      end
   end

   always_comb begin
      state_d     = state_q;
      mc_start_d  = 1'b0;
      mc_inp_d    = mc_inp_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      pop         = 1'b0;
`ifdef MC_TIMEOUT_EN
      cnt_d       = cnt_q;
      timeout_d   = timeout_q;
`endif
      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
      case (state_q)
         ST_IDLE: begin
            // Gating on the registered out_valid delays issue by one edge after the result drains.
            if (!empty && !out_valid_q) begin
               state_d    = ST_WAIT;
               mc_start_d = 1'b1;
               mc_inp_d   = head;
               pop        = 1'b1;
`ifdef MC_TIMEOUT_EN
               cnt_d      = '0;
`endif
            end
         end
         ST_WAIT: begin
            // A done overlapping the start pulse belongs to no operation of ours.
            if (mc_done && !mc_start_q) begin
               out_data_d  = mc_out;
               out_valid_d = 1'b1;
               state_d     = ST_IDLE;
            end
`ifdef MC_TIMEOUT_EN
            else if (cnt_q == CNT_LAST) begin
               out_data_d  = '1;
               out_valid_d = 1'b1;
               timeout_d   = 1'b1;
               state_d     = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
`endif
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         mc_start_q  <= 1'b0;
         mc_inp_q    <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
`ifdef MC_TIMEOUT_EN
         cnt_q       <= '0;
         timeout_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         mc_start_q  <= mc_start_d;
         mc_inp_q    <= mc_inp_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
`ifdef MC_TIMEOUT_EN
         cnt_q       <= cnt_d;
         timeout_q   <= timeout_d;
`endif
      end
   end

   assign mc_start  = mc_start_q;
   assign mc_inp    = mc_inp_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign busy      = (state_q == ST_WAIT) || !empty || out_valid_q;
`ifdef MC_TIMEOUT_EN
   assign timeout_err = timeout_q;
`else
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_driver.sv
// Directed bench for multicycle_driver: vector table plus hand-written corner sequences.
module tb_multicycle_driver;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic        mc_start;
   logic [31:0] mc_inp;
   logic        mc_done;
   logic [31:0] mc_out;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic        busy;
   logic        timeout_err;

   logic        model_done = 1'b0;
   logic [31:0] model_out = '0;
   logic        man_done = 1'b0;
   logic [31:0] man_out = '0;

   assign mc_done = model_done | man_done;
   assign mc_out  = man_done ? man_out : model_out;

   multicycle_driver #(.WIDTH(32), .FIFO_DEPTH(2), .TIMEOUT_CYCLES(16)) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .mc_start(mc_start), .mc_inp(mc_inp), .mc_done(mc_done), .mc_out(mc_out),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Identity unit: done appears unit_delay cycles after the cycle following the start pulse.
   bit          unit_en = 1'b1;
   int          unit_delay = 0;
   bit          pend = 1'b0;
   int          dly = 0;
   logic [31:0] hold = '0;

   always @(negedge clock) begin
      model_done = 1'b0;
      if (!unit_en || !reset) begin
         pend = 1'b0;
      end else if (mc_start) begin
         pend = 1'b1;
         dly  = unit_delay;
         hold = mc_inp;
      end else if (pend) begin
         if (dly == 0) begin
            model_done = 1'b1;
            model_out  = hold;
            pend       = 1'b0;
         end else begin
            dly--;
         end
      end
   end

   int starts = 0;
   always @(posedge clock) if (mc_start) starts++;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input logic [31:0] d);
      in_valid = 1'b1;
      in_data  = d;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_out(input string name, output int lat);
      lat = 0;
      for (int k = 1; k <= 100; k++) begin
         tick();
         if (out_valid) begin
            lat = k;
            break;
         end
      end
      if (lat == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: out_valid never rose, got 0 expected 1 within 100 cycles", name);
      end
   endtask

   task automatic drain();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   typedef struct {
      logic [31:0] operand;
      int          delay;
      int          stall;
      logic [31:0] expected;
      int          latency;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int lat;
      int s0;
      logic [31:0] got[$];

      vecs[0] = '{32'h1234_5678, 0, 0, 32'h1234_5678, 3};
      vecs[1] = '{32'hDEAD_BEEF, 1, 2, 32'hDEAD_BEEF, 4};
      vecs[2] = '{32'h0000_0000, 3, 0, 32'h0000_0000, 6};
      vecs[3] = '{32'hFFFF_FFFF, 0, 1, 32'hFFFF_FFFF, 3};
      vecs[4] = '{32'h0000_0055, 2, 5, 32'h0000_0055, 5};

      // Reset state
      #12;
      chk("rst in_ready", in_ready, 1);
      chk("rst mc_start", mc_start, 0);
      chk("rst mc_inp", mc_inp, 0);
      chk("rst out_valid", out_valid, 0);
      chk("rst out_data", out_data, 0);
      chk("rst busy", busy, 0);
      chk("rst timeout_err", timeout_err, 0);
      tick();
      reset = 1'b1;
      tick();

      // out_ready with nothing pending has no effect
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("idle out_ready out_valid", out_valid, 0);

      // Single operand, exact pulse timing
      unit_delay = 0;
      push(32'h1234_5678);
      chk("single N mc_start", mc_start, 0);
      chk("single N busy", busy, 1);
      tick();
      chk("single N+1 mc_start", mc_start, 1);
      chk("single N+1 mc_inp", mc_inp, 32'h1234_5678);
      tick();
      chk("single N+2 mc_start", mc_start, 0);
      chk("single N+2 out_valid", out_valid, 0);
      tick();
      chk("single N+3 out_valid", out_valid, 1);
      chk("single N+3 out_data", out_data, 32'h1234_5678);
      drain();
      chk("single drained out_valid", out_valid, 0);
      chk("single drained busy", busy, 0);
      chk("single mc_inp held", mc_inp, 32'h1234_5678);

      // Table of single transactions with varying unit delay and output stall
      foreach (vecs[i]) begin
         unit_delay = vecs[i].delay;
         push(vecs[i].operand);
         wait_out($sformatf("vec%0d wait", i), lat);
         chk($sformatf("vec%0d latency", i), lat, vecs[i].latency);
         chk($sformatf("vec%0d out_data", i), out_data, vecs[i].expected);
         for (int s = 0; s < vecs[i].stall; s++) begin
            tick();
            chk($sformatf("vec%0d stall valid", i), out_valid, 1);
            chk($sformatf("vec%0d stall data", i), out_data, vecs[i].expected);
         end
         drain();
         chk($sformatf("vec%0d cleared", i), out_valid, 0);
         chk($sformatf("vec%0d busy", i), busy, 0);
         chk($sformatf("vec%0d mc_inp held", i), mc_inp, vecs[i].operand);
      end

      // Back-to-back with full FIFO; 0xD offered while full must be dropped
      unit_delay = 1;
      s0 = starts;
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_data = 32'hA;
      tick();
      in_data = 32'hB;
      tick();
      in_data = 32'hC;
      tick();
      chk("b2b full in_ready", in_ready, 0);
      in_data = 32'hD;
      tick();
      in_valid = 1'b0;
      chk("b2b still full", in_ready, 0);
      for (int k = 0; k < 40; k++) begin
         tick();
         if (out_valid) got.push_back(out_data);
      end
      out_ready = 1'b0;
      chk("b2b result count", got.size(), 3);
      if (got.size() == 3) begin
         chk("b2b result0", got[0], 32'hA);
         chk("b2b result1", got[1], 32'hB);
         chk("b2b result2", got[2], 32'hC);
      end
      chk("b2b start cycles", starts - s0, 3);
      chk("b2b busy", busy, 0);

      // Output stall blocks the next issue until one edge after out_ready
      unit_delay = 0;
      in_valid = 1'b1;
      in_data = 32'h55;
      tick();
      in_data = 32'h66;
      tick();
      in_valid = 1'b0;
      wait_out("stall wait", lat);
      chk("stall first data", out_data, 32'h55);
      s0 = starts;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("stall valid", out_valid, 1);
         chk("stall data", out_data, 32'h55);
         chk("stall no start", mc_start, 0);
      end
      chk("stall start count", starts - s0, 0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("stall release valid", out_valid, 0);
      chk("stall release no start", mc_start, 0);
      tick();
      chk("stall next start", mc_start, 1);
      chk("stall next mc_inp", mc_inp, 32'h66);
      wait_out("stall second wait", lat);
      chk("stall second data", out_data, 32'h66);
      drain();

      // Spurious done: in IDLE and coincident with the start pulse
      unit_en = 1'b0;
      man_out = 32'hBAD0_BAD0;
      man_done = 1'b1;
      tick();
      man_done = 1'b0;
      chk("spur idle out_valid", out_valid, 0);
      chk("spur idle busy", busy, 0);
      push(32'h77);
      tick();
      chk("spur start", mc_start, 1);
      man_done = 1'b1;
      tick();
      man_done = 1'b0;
      chk("spur coincident out_valid", out_valid, 0);
      chk("spur coincident busy", busy, 1);
      repeat (3) tick();
      chk("spur waiting out_valid", out_valid, 0);
      man_out = 32'h77;
      man_done = 1'b1;
      tick();
      man_done = 1'b0;
      chk("spur real out_valid", out_valid, 1);
      chk("spur real out_data", out_data, 32'h77);
      drain();

      // Reset during the start pulse with one entry still queued
      in_valid = 1'b1;
      in_data = 32'h11;
      tick();
      in_data = 32'h22;
      tick();
      in_valid = 1'b0;
      chk("rstmid pre mc_start", mc_start, 1);
      chk("rstmid pre busy", busy, 1);
      #2 reset = 1'b0;
      #1;
      chk("rstmid mc_start", mc_start, 0);
      chk("rstmid busy", busy, 0);
      chk("rstmid in_ready", in_ready, 1);
      chk("rstmid mc_inp", mc_inp, 0);
      chk("rstmid out_data", out_data, 0);
      tick();
      reset = 1'b1;
      s0 = starts;
      tick();
      man_out = 32'h11;
      man_done = 1'b1;
      tick();
      man_done = 1'b0;
      repeat (3) tick();
      chk("rstmid late done out_valid", out_valid, 0);
      chk("rstmid late busy", busy, 0);
      chk("rstmid no restart", starts - s0, 0);

`ifdef MC_TIMEOUT_EN
      push(32'h99);
      repeat (16) tick();
      chk("tmo before out_valid", out_valid, 0);
      chk("tmo before err", timeout_err, 0);
      tick();
      chk("tmo out_valid", out_valid, 1);
      chk("tmo out_data", out_data, 32'hFFFF_FFFF);
      chk("tmo err", timeout_err, 1);
      drain();
      man_out = 32'h99;
      man_done = 1'b1;
      tick();
      man_done = 1'b0;
      tick();
      chk("tmo late done", out_valid, 0);
      chk("tmo sticky", timeout_err, 1);
      chk("tmo busy", busy, 0);
      reset = 1'b0;
      #1;
      chk("tmo cleared by reset", timeout_err, 0);
      tick();
      reset = 1'b1;
`else
      push(32'h99);
      repeat (40) tick();
      chk("notmo out_valid", out_valid, 0);
      chk("notmo err", timeout_err, 0);
      chk("notmo busy", busy, 1);
      reset = 1'b0;
      #1;
      chk("notmo reset busy", busy, 0);
      tick();
      reset = 1'b1;
`endif

      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
